// File: rtl/cordic_arbiter.sv
// Round-robin front end that shares one iterative CORDIC sine/cosine engine
// between NREQ clients and returns ID-tagged results on a valid/ready channel.
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_angle,
    output logic [NREQ-1:0]     req_ready,
    output logic                eng_start,
    output logic [7:0]          eng_angle,
    input  logic                eng_done,
    input  logic [7:0]          eng_sine,
    input  logic [7:0]          eng_cosine,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic [7:0]          res_sine,
    output logic [7:0]          res_cosine,
    output logic                res_err,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [IDW-1:0] ptr;
    logic [7:0]     angle_q;
    logic [IDW-1:0] id_q;
    logic [CW-1:0]  wait_cnt;
    logic [7:0]     sine_q;
    logic [7:0]     cosine_q;
    logic           err_q;

    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic           wait_expired;

    // Pick the valid requester with the smallest forward distance from p.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  p);
        int          best_d;
        int          d;
        logic [IDW:0] r;
        best_d = NREQ;
        r      = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(p);
            if (d < 0) d = d + NREQ;
            if (v[i] && (d < best_d)) begin
                best_d = d;
                r      = {1'b1, IDW'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] g);
        return (int'(g) == NREQ - 1) ? '0 : g + IDW'(1);
    endfunction

    function automatic logic [7:0] angle_of(input logic [8*NREQ-1:0] a,
                                            input logic [IDW-1:0]    g);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == g) r = a[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        {grant_any, grant_id} = rr_pick(req_valid, ptr);
    end

    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        eng_start = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (grant_any) begin
                    req_ready[grant_id] = 1'b1;
                    state_nxt           = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                eng_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done || wait_expired) state_nxt = S_DELIVER;
            end
            S_DELIVER: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture on grant, time the engine in WAIT; a done pulse beats the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            angle_q  <= '0;
            id_q     <= '0;
            wait_cnt <= '0;
            sine_q   <= '0;
            cosine_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        angle_q <= angle_of(req_angle, grant_id);
                        id_q    <= grant_id;
                        ptr     <= wrap_inc(grant_id);
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        sine_q   <= eng_sine;
                        cosine_q <= eng_cosine;
                        err_q    <= 1'b0;
                    end else if (wait_expired) begin
                        sine_q   <= '0;
                        cosine_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign eng_angle  = angle_q;
    assign res_id     = id_q;
    assign res_sine   = sine_q;
    assign res_cosine = cosine_q;
    assign res_err    = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: directed scenarios with literal expectations plus a
// transaction-style model checked against the outputs on every cycle.
module tb_cordic_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;
    localparam int CW      = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [8*NREQ-1:0] req_angle;
    logic [NREQ-1:0] req_ready;
    logic            eng_start;
    logic [7:0]      eng_angle;
    logic            eng_done;
    logic [7:0]      eng_sine;
    logic [7:0]      eng_cosine;
    logic            res_valid;
    logic            res_ready;
    logic [IDW-1:0]  res_id;
    logic [7:0]      res_sine;
    logic [7:0]      res_cosine;
    logic            res_err;
    logic            busy;

    cordic_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .eng_start(eng_start), .eng_angle(eng_angle), .eng_done(eng_done),
        .eng_sine(eng_sine), .eng_cosine(eng_cosine),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_sine(res_sine), .res_cosine(res_cosine), .res_err(res_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int eng_delay = 0;
    int eng_cnt   = 0;
    int gq[$];
    int exp_order[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    endtask

    // Engine stand-in: done pulses eng_delay cycles after start (0 = never).
    initial begin
        eng_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) eng_done = 1'b1;
            end
            if (eng_start === 1'b1 && eng_delay > 0) eng_cnt = eng_delay;
        end
    end

    // Reference model: one outstanding job, its age since grant, and its result.
    bit        armed = 1'b0;
    bit        m_active = 1'b0;
    bit        m_res = 1'b0;
    int        m_age = 0;
    int        m_ptr = 0;
    int        m_id = 0;
    logic [7:0] m_angle = 8'h00;
    logic [7:0] m_sine = 8'h00;
    logic [7:0] m_cos = 8'h00;
    bit        m_err = 1'b0;

    initial begin : compare
        int g;
        int c;
        int gid;
        logic [NREQ-1:0] exp_ready;
        forever begin
            @(negedge clk);
            g = -1;
            exp_ready = '0;
            if (!m_active) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            if (armed) begin
                check("cyc_req_ready", 32'(req_ready), 32'(exp_ready));
                check("cyc_eng_start", 32'(eng_start), 32'(m_active && m_age == 1));
                check("cyc_eng_angle", 32'(eng_angle), 32'(m_angle));
                check("cyc_busy", 32'(busy), 32'(m_active));
                check("cyc_res_valid", 32'(res_valid), 32'(m_res));
                if (m_res) begin
                    check("cyc_res_id", 32'(res_id), 32'(m_id));
                    check("cyc_res_sine", 32'(res_sine), 32'(m_sine));
                    check("cyc_res_cosine", 32'(res_cosine), 32'(m_cos));
                    check("cyc_res_err", 32'(res_err), 32'(m_err));
                end
                if (req_ready != '0) begin
                    gid = -1;
                    for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
                    gq.push_back(gid);
                end
            end
            if (rst) begin
                armed = 1'b1; m_active = 1'b0; m_res = 1'b0; m_age = 0; m_ptr = 0;
                m_id = 0; m_angle = 8'h00; m_sine = 8'h00; m_cos = 8'h00; m_err = 1'b0;
            end else if (!m_active) begin
                if (g >= 0) begin
                    m_active = 1'b1; m_age = 1; m_id = g;
                    m_angle = req_angle[8*g +: 8];
                    m_ptr = (g + 1) % NREQ;
                end
            end else if (m_res) begin
                if (res_ready) begin
                    m_active = 1'b0; m_res = 1'b0;
                end
            end else begin
                if (m_age >= 2) begin
                    if (eng_done) begin
                        m_res = 1'b1; m_sine = eng_sine; m_cos = eng_cosine; m_err = 1'b0;
                    end else if (m_age == TIMEOUT + 1) begin
                        m_res = 1'b1; m_sine = 8'h00; m_cos = 8'h00; m_err = 1'b1;
                    end
                end
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic wait_valid(input int max, input string name);
        int n;
        n = 0;
        sample();
        while (res_valid !== 1'b1 && n < max) begin
            sample();
            n++;
        end
        if (res_valid !== 1'b1) check(name, 32'(res_valid), 32'(1));
    endtask

    task automatic wait_idle(input int max, input string name);
        int n;
        n = 0;
        sample();
        while ((busy !== 1'b0 || res_valid !== 1'b0) && n < max) begin
            sample();
            n++;
        end
        if (busy !== 1'b0) check(name, 32'(busy), 32'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 32'({req_ready, eng_start, eng_angle, res_valid, res_id, busy}), 32'(0));
        check({name, "_data"}, 32'({res_sine, res_cosine, res_err}), 32'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin : stim
        int t_grant;
        int n;
        rst = 1'b1; req_valid = '0; req_angle = 32'h44_33_20_11;
        res_ready = 1'b0; eng_sine = 8'h00; eng_cosine = 8'h00;
        tick(); tick();
        rst = 1'b0;
        sample();
        check_all_zero("reset_outputs");

        // Single request from requester 1
        tick();
        req_valid = 4'b0010; eng_delay = 11; eng_sine = 8'h1F; eng_cosine = 8'h3A; res_ready = 1'b1;
        sample();
        check("t1_grant", 32'(req_ready), 32'(4'b0010));
        t_grant = cyc;
        tick();
        req_valid = '0;
        sample();
        check("t1_start", 32'(eng_start), 32'(1));
        check("t1_angle", 32'(eng_angle), 32'(8'h20));
        wait_valid(20, "t1_valid_bound");
        check("t1_latency", 32'(cyc - t_grant), 32'(13));
        check("t1_id", 32'(res_id), 32'(1));
        check("t1_sine", 32'(res_sine), 32'(8'h1F));
        check("t1_cosine", 32'(res_cosine), 32'(8'h3A));
        check("t1_err", 32'(res_err), 32'(0));
        tick();
        sample();
        check("t1_valid_drop", 32'(res_valid), 32'(0));

        // Round-robin with all requesting, then requester 0 drops out
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        gq.delete();
        eng_delay = 3; eng_sine = 8'h05; eng_cosine = 8'h40;
        req_valid = 4'b1111;
        n = 0;
        while (gq.size() < 5 && n < 200) begin sample(); n++; end
        tick();
        req_valid = 4'b1110;
        n = 0;
        while (gq.size() < 9 && n < 200) begin sample(); n++; end
        tick();
        req_valid = '0;
        wait_idle(40, "t2_idle_bound");
        check("t2_grant_count", 32'(gq.size()), 32'(9));
        for (int i = 0; i < 9; i++) begin
            if (i < gq.size()) check("t2_grant_order", 32'(gq[i]), 32'(exp_order[i]));
        end

        // Backpressure in DELIVER
        eng_sine = 8'h0C; eng_cosine = 8'h7F;
        tick();
        req_valid = 4'b0001; res_ready = 1'b0;
        sample();
        check("t3_grant", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = 4'b1111;
        wait_valid(20, "t3_valid_bound");
        check("t3_id", 32'(res_id), 32'(0));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) sample();
            check("t3_hold_valid", 32'(res_valid), 32'(1));
            check("t3_hold_sine", 32'(res_sine), 32'(8'h0C));
            check("t3_hold_cosine", 32'(res_cosine), 32'(8'h7F));
            check("t3_hold_busy", 32'(busy), 32'(1));
            check("t3_no_grant", 32'(req_ready), 32'(0));
        end
        tick();
        res_ready = 1'b1;
        sample();
        check("t3_handshake_no_grant", 32'(req_ready), 32'(0));
        tick();
        sample();
        check("t3_next_grant", 32'(req_ready), 32'(4'b0010));
        check("t3_idle_valid", 32'(res_valid), 32'(0));
        tick();
        req_valid = '0;
        wait_idle(40, "t3_idle_bound");

        // Timeout, late done while held in DELIVER
        eng_sine = 8'h55; eng_cosine = 8'hAA; eng_delay = 19;
        tick();
        req_valid = 4'b0100; res_ready = 1'b0;
        sample();
        check("t4_grant", 32'(req_ready), 32'(4'b0100));
        t_grant = cyc;
        tick();
        req_valid = '0;
        wait_valid(30, "t4_valid_bound");
        check("t4_latency", 32'(cyc - t_grant), 32'(18));
        check("t4_err", 32'(res_err), 32'(1));
        check("t4_data_zero", 32'({res_sine, res_cosine}), 32'(0));
        check("t4_id", 32'(res_id), 32'(2));
        for (int i = 0; i < 4; i++) begin
            sample();
            check("t4_late_done_err", 32'(res_err), 32'(1));
            check("t4_late_done_sine", 32'(res_sine), 32'(0));
        end
        tick();
        res_ready = 1'b1;
        wait_idle(10, "t4_idle_bound");

        // Timeout, late done lands in IDLE
        eng_delay = 30;
        tick();
        req_valid = 4'b1000;
        sample();
        check("t4b_grant", 32'(req_ready), 32'(4'b1000));
        tick();
        req_valid = '0;
        wait_valid(30, "t4b_valid_bound");
        check("t4b_err", 32'(res_err), 32'(1));
        wait_idle(10, "t4b_idle_bound");
        repeat (20) sample();
        check("t4b_idle_valid", 32'(res_valid), 32'(0));
        check("t4b_idle_busy", 32'(busy), 32'(0));

        // Done on the final WAIT cycle beats the timeout
        eng_sine = 8'h2A; eng_cosine = 8'hC5; eng_delay = 16;
        tick();
        req_valid = 4'b0001;
        sample();
        check("t5_grant", 32'(req_ready), 32'(4'b0001));
        t_grant = cyc;
        tick();
        req_valid = '0;
        wait_valid(30, "t5_valid_bound");
        check("t5_latency", 32'(cyc - t_grant), 32'(18));
        check("t5_err", 32'(res_err), 32'(0));
        check("t5_sine", 32'(res_sine), 32'(8'h2A));
        check("t5_cosine", 32'(res_cosine), 32'(8'hC5));
        wait_idle(10, "t5_idle_bound");

        // Reset mid-WAIT
        eng_delay = 8;
        tick();
        req_valid = 4'b0010;
        sample();
        check("t6_grant", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("t6_in_wait", 32'(busy), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        check_all_zero("t6_after_reset");
        repeat (8) sample();
        check("t6_no_result", 32'(res_valid), 32'(0));
        check("t6_no_busy", 32'(busy), 32'(0));
        tick();
        req_valid = 4'b1000;
        sample();
        check("t6_grant_after_reset", 32'(req_ready), 32'(4'b1000));
        tick();
        req_valid = '0;
        wait_valid(30, "t6_valid_bound");
        check("t6_id", 32'(res_id), 32'(3));
        wait_idle(10, "t6_idle_bound");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
